// File: rtl/spi_instr_loader.sv
// SPI-slave (mode 0) loader that writes 16-bit instruction words into the instruction register file.
// All SPI pins are oversampled in the clk domain; frame = command byte then back-to-back data words.
module spi_instr_loader #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  write_addr,
  output logic               write_en,
  output logic               busy,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(INSTR_W);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_t;

  logic               sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic               cs_s1_q, cs_s2_q, cs_s3_q;
  logic               mosi_s1_q, mosi_s2_q;
  logic               sclk_rise, cs_fall, cs_rise;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] shift_q, shift_d, shift_nx;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic               wen_q, wen_d;
  logic               ferr_q, ferr_d;
  logic [1:0]         fill_q, fill_d;
  logic               armed_q, armed_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_s3_q <= 1'b0;
      cs_s1_q   <= 1'b1; cs_s2_q   <= 1'b1; cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0; mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;      sclk_s2_q <= sclk_s1_q; sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= cs_n;      cs_s2_q   <= cs_s1_q;   cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= mosi;      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign cs_fall   = ~cs_s2_q & cs_s3_q;
  assign cs_rise   = cs_s2_q & ~cs_s3_q;
  assign shift_nx  = {shift_q[INSTR_W-2:0], mosi_s2_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      waddr_q <= '0;
      wen_q   <= 1'b0;
      ferr_q  <= 1'b0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
      ferr_q  <= ferr_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    waddr_d = waddr_q;
    wen_d   = 1'b0;
    ferr_d  = ferr_q;
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    // A cs_n still held low across reset must not look like a fresh fall:
    // only arm once the synchroniser holds real pin values and cs_n was seen high.
    armed_d = armed_q | ((fill_q == 2'd3) & cs_s2_q);

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = CMD;
          cnt_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
        end else if (sclk_rise) begin
          shift_d = shift_nx;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (shift_q[6]) begin
              addr_d  = shift_nx[ADDR_W-1:0];
              state_d = DATA;
            end else begin
              state_d = DISCARD;
            end
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
        end else if (sclk_rise) begin
          shift_d = shift_nx;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(INSTR_W - 1)) begin
            cnt_d   = '0;
            instr_d = shift_nx;
            waddr_d = addr_q;
            wen_d   = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
      end
      DISCARD: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_in   = instr_q;
  assign write_addr = waddr_q;
  assign write_en   = wen_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = ferr_q;

endmodule
